rv32i_decode: RTL and testbench
===============================

# rv32i_decode

Registered RV32I instruction decoder for the core's decode stage. It accepts one 32-bit instruction word per cycle and splits it into its fields. It produces the sign-extended immediate, the instruction format and the datapath control signals. All outputs are registered and appear one clock after the instruction is sampled.

## Interface
- No parameters. XLEN is fixed at 32.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst  in  32  instruction word, sampled every rising edge.
- opcode  out  7  inst[6:0].
- rd  out  5  inst[11:7].
- funct3  out  3  inst[14:12].
- rs1  out  5  inst[19:15].
- rs2  out  5  inst[24:20].
- funct7  out  7  inst[31:25].
- imm  out  32  immediate, sign-extended for the decoded format; 0 for R-type and illegal.
- fmt  out  3  format enum: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- alu_op  out  4  ALU operation enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
- alu_src_imm  out  1  ALU operand B is imm (1) or rs2 (0).
- reg_write  out  1  writes rd.
- mem_read  out  1  load.
- mem_write  out  1  store.
- branch  out  1  conditional branch; funct3 selects the condition.
- jump  out  1  JAL or JALR.
- illegal  out  1  opcode, or an opcode/funct combination, is not in RV32I base.

## Operation
- The field outputs are always raw bit slices of the sampled inst, including when the instruction is illegal.
- Opcode to format and controls:
  - 0x33 (OP): fmt R; reg_write=1; alu_op from funct3 and funct7[5].
    - SUB only with funct3=0, funct7=0x20.
    - SRA only with funct3=5, funct7=0x20.
    - Any other funct7 besides 0x00 is illegal.
  - 0x13 (OP-IMM): fmt I; alu_src_imm=1; reg_write=1.
    - SLLI requires funct7=0x00.
    - SRLI/SRAI require funct7 of 0x00 or 0x20.
  - 0x03 (LOAD): fmt I; mem_read=1; reg_write=1; alu_op ADD; alu_src_imm=1.
    - funct3 of 3, 6 or 7 is illegal.
  - 0x23 (STORE): fmt S; mem_write=1; alu_op ADD; alu_src_imm=1.
    - funct3 of 3 or more is illegal.
  - 0x63 (BRANCH): fmt B; branch=1; alu_op SUB.
    - funct3 of 2 or 3 is illegal.
  - 0x37 (LUI): fmt U; reg_write=1; alu_op PASS_B; alu_src_imm=1.
  - 0x17 (AUIPC): fmt U; reg_write=1; alu_op ADD; alu_src_imm=1.
  - 0x6F (JAL): fmt J; jump=1; reg_write=1.
  - 0x67 (JALR): fmt I; jump=1; reg_write=1; alu_op ADD; alu_src_imm=1.
    - funct3≠0 is illegal.
  - 0x0F (FENCE) and 0x73 (SYSTEM): fmt I; all controls 0; not illegal (treated as NOP).
  - Any other opcode: illegal=1, fmt NONE.
- Immediates (sign bit inst[31]):
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U = {inst[31:12], 12'b0}.
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- When illegal=1:
  - reg_write, mem_read, mem_write, branch, jump, alu_src_imm = 0.
  - alu_op = ADD; imm = 0.

## Timing
- Latency is exactly 1 cycle. Outputs reflect the inst sampled at the previous rising edge.
- There is no handshake and no stall. A new instruction is accepted every cycle.
- While rst=1 at an edge, every output register clears to 0, except fmt, which resets to NONE.
- Reset mid-stream discards the instruction sampled at that edge. The first decode appears one cycle after the first edge with rst=0.
- rst has priority over inst on the same edge.

## Structure
- Package rv32i_pkg holds:
  - the opcode localparams;
  - the fmt_t and alu_op_t enums;
  - the funct7 constants 0x00 and 0x20.
- One combinational sub-module, rv32i_imm_gen (inst, fmt → imm), builds the immediate.
- The top level holds the combinational control decode and the output register stage.

## Test plan
- ADD x3,x1,x2: 0x002081B3 → after 1 clk, all of:
  - opcode=0x33, rd=3, funct3=0, rs1=1, rs2=2, funct7=0;
  - fmt R, alu_op ADD, reg_write=1, illegal=0.
- ADDI x1,x0,-1: 0xFFF00093 → fmt I, imm=0xFFFFFFFF, alu_src_imm=1. Also 0x40208133 (SUB) → alu_op SUB.
- SW x2,8(x1): 0x0020A423 → fmt S, imm=8, mem_write=1, reg_write=0.
- BEQ x1,x2,+8: 0x00208463 → fmt B, imm=8, branch=1.
- LUI x5,0x12345: 0x123452B7 → fmt U, imm=0x12345000, alu_op PASS_B.
- 0x00000000 → illegal=1, fmt NONE, all controls 0. Assert rst for one cycle mid-stream → all outputs 0 and fmt NONE on the next cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared opcodes, format/ALU enums and funct7 constants for the RV32I decoder.
package rv32i_pkg;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_FENCE  = 7'h0F;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef enum logic [2:0] {
      FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
      FMT_U = 3'd4, FMT_J = 3'd5, FMT_NONE = 3'd7
   } fmt_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_op_t;

   // alt selects SUB/SRA; callers decide when bit 30 is meaningful
   function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0: return alt ? ALU_SUB : ALU_ADD;
         3'd1: return ALU_SLL;
         3'd2: return ALU_SLT;
         3'd3: return ALU_SLTU;
         3'd4: return ALU_XOR;
         3'd5: return alt ? ALU_SRA : ALU_SRL;
         3'd6: return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction
endpackage

// File: rtl/rv32i_imm_gen.sv
// rv32i_imm_gen: sign-extended immediate for the decoded instruction format.
module rv32i_imm_gen
   import rv32i_pkg::*;
(
   input  logic [31:7] inst,
   input  fmt_t        fmt,
   output logic [31:0] imm
);
   assign imm = fmt == FMT_I ? {{20{inst[31]}}, inst[31:20]} :
                fmt == FMT_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                fmt == FMT_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                fmt == FMT_U ? {inst[31:12], 12'b0} :
                fmt == FMT_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                32'b0;
endmodule

// File: rtl/rv32i_decode.sv
// rv32i_decode: registered RV32I decoder producing fields, immediate, format and datapath controls.
module rv32i_decode
   import rv32i_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   output logic [6:0]  opcode,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  funct7,
   output logic [31:0] imm,
   output logic [2:0]  fmt,
   output logic [3:0]  alu_op,
   output logic        alu_src_imm,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        branch,
   output logic        jump,
   output logic        illegal
);
   fmt_t        fmt_c;
   alu_op_t     alu_c;
   logic        src_c, rw_c, mr_c, mw_c, br_c, jp_c, ill_c;
   logic [31:0] imm_c;
   logic [2:0]  f3;
   logic [6:0]  f7;

   assign f3 = inst[14:12];
   assign f7 = inst[31:25];

   rv32i_imm_gen u_imm (.inst(inst[31:7]), .fmt(fmt_c), .imm(imm_c));

   always_comb begin
      fmt_c = FMT_NONE;
      alu_c = ALU_ADD;
      {src_c, rw_c, mr_c, mw_c, br_c, jp_c, ill_c} = '0;
      case (inst[6:0])
         OPC_OP: begin
            fmt_c = FMT_R;
            rw_c  = 1'b1;
            alu_c = alu_from_f3(f3, f7 == F7_ALT);
            ill_c = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)));
         end
         OPC_OP_IMM: begin
            fmt_c = FMT_I;
            {src_c, rw_c} = 2'b11;
            // bit 30 is part of the immediate except for the shift-right pair
            alu_c = alu_from_f3(f3, f3 == 3'd5 && f7 == F7_ALT);
            ill_c = f3 == 3'd1 ? f7 != F7_BASE :
                    f3 == 3'd5 ? !(f7 == F7_BASE || f7 == F7_ALT) : 1'b0;
         end
         OPC_LOAD: begin
            fmt_c = FMT_I;
            {src_c, rw_c, mr_c} = 3'b111;
            ill_c = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
         end
         OPC_STORE: begin
            fmt_c = FMT_S;
            {src_c, mw_c} = 2'b11;
            ill_c = f3 >= 3'd3;
         end
         OPC_BRANCH: begin
            fmt_c = FMT_B;
            br_c  = 1'b1;
            alu_c = ALU_SUB;
            ill_c = f3 == 3'd2 || f3 == 3'd3;
         end
         OPC_LUI: begin
            fmt_c = FMT_U;
            {src_c, rw_c} = 2'b11;
            alu_c = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            fmt_c = FMT_U;
            {src_c, rw_c} = 2'b11;
         end
         OPC_JAL: begin
            fmt_c = FMT_J;
            {rw_c, jp_c} = 2'b11;
         end
         OPC_JALR: begin
            fmt_c = FMT_I;
            {src_c, rw_c, jp_c} = 3'b111;
            ill_c = f3 != 3'd0;
         end
         OPC_FENCE, OPC_SYSTEM: fmt_c = FMT_I;
         default: ill_c = 1'b1;
      endcase
      if (ill_c) begin
         {src_c, rw_c, mr_c, mw_c, br_c, jp_c} = '0;
         alu_c = ALU_ADD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {opcode, rd, funct3, rs1, rs2, funct7, imm, alu_op} <= '0;
         {alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal} <= '0;
         fmt <= FMT_NONE;
      end else begin
         opcode      <= inst[6:0];
         rd          <= inst[11:7];
         funct3      <= f3;
         rs1         <= inst[19:15];
         rs2         <= inst[24:20];
         funct7      <= f7;
         imm         <= ill_c ? 32'b0 : imm_c;
         fmt         <= fmt_c;
         alu_op      <= alu_c;
         alu_src_imm <= src_c;
         reg_write   <= rw_c;
         mem_read    <= mr_c;
         mem_write   <= mw_c;
         branch      <= br_c;
         jump        <= jp_c;
         illegal     <= ill_c;
      end
   end
endmodule

// File: tb/tb_rv32i_decode.sv
// tb_rv32i_decode: directed and random instructions checked against a table-driven decode model.
module tb_rv32i_decode;
   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4,
                          A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9,
                          A_PASS_B = 4'd10;

   typedef struct {
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic [3:0]  alu;
      logic        src, rw, mr, mw, br, jp, ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3, fmt;
   logic [31:0] imm;
   logic [3:0]  alu_op;
   logic        alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] cur_inst;
   logic [3:0]  f3_alu [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
   logic [6:0]  opcs [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17,
                              7'h6F, 7'h67, 7'h0F, 7'h73, 7'h00};

   rv32i_decode dut (
      .clk(clk), .rst(rst), .inst(inst),
      .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
      .imm(imm), .fmt(fmt), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .jump(jump), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (inst %h)", tag, got, exp, cur_inst);
      end
   endtask

   // Reference decode: immediates rebuilt by shifting fields into place over a sign mask
   function automatic exp_t model(input logic [31:0] i);
      exp_t        e;
      logic [31:0] sx;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
      f3 = i[14:12];
      f7 = i[31:25];
      imm_i = (sx << 11) | 32'(i[30:20]);
      imm_s = (sx << 11) | (32'(i[30:25]) << 5) | 32'(i[11:7]);
      imm_b = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      imm_u = i & 32'hFFFF_F000;
      imm_j = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      e = '{imm: 32'h0, fmt: 3'd7, alu: A_ADD, src: 0, rw: 0, mr: 0, mw: 0, br: 0, jp: 0, ill: 0};
      case (i[6:0])
         7'h33: begin
            e.fmt = 3'd0; e.rw = 1;
            if (f7 == 7'h00) e.alu = f3_alu[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.alu = A_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) e.alu = A_SRA;
            else e.ill = 1;
         end
         7'h13: begin
            e.fmt = 3'd1; e.src = 1; e.rw = 1; e.imm = imm_i; e.alu = f3_alu[f3];
            if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1;
            if (f3 == 3'd5) begin
               if (f7 == 7'h20) e.alu = A_SRA;
               else if (f7 != 7'h00) e.ill = 1;
            end
         end
         7'h03: begin
            e.fmt = 3'd1; e.mr = 1; e.rw = 1; e.src = 1; e.imm = imm_i;
            e.ill = f3 inside {3'd3, 3'd6, 3'd7};
         end
         7'h23: begin
            e.fmt = 3'd2; e.mw = 1; e.src = 1; e.imm = imm_s;
            e.ill = f3 > 3'd2;
         end
         7'h63: begin
            e.fmt = 3'd3; e.br = 1; e.alu = A_SUB; e.imm = imm_b;
            e.ill = f3 inside {3'd2, 3'd3};
         end
         7'h37: begin e.fmt = 3'd4; e.rw = 1; e.alu = A_PASS_B; e.src = 1; e.imm = imm_u; end
         7'h17: begin e.fmt = 3'd4; e.rw = 1; e.src = 1; e.imm = imm_u; end
         7'h6F: begin e.fmt = 3'd5; e.jp = 1; e.rw = 1; e.imm = imm_j; end
         7'h67: begin
            e.fmt = 3'd1; e.jp = 1; e.rw = 1; e.src = 1; e.imm = imm_i;
            e.ill = f3 != 3'd0;
         end
         7'h0F, 7'h73: begin e.fmt = 3'd1; e.imm = imm_i; end
         default: e.ill = 1;
      endcase
      if (e.ill) begin
         e.imm = 0; e.alu = A_ADD;
         {e.src, e.rw, e.mr, e.mw, e.br, e.jp} = '0;
      end
      return e;
   endfunction

   task automatic check_decode(input logic [31:0] v);
      exp_t e;
      e = model(v);
      chk("opcode", 32'(opcode), 32'(v[6:0]));
      chk("rd", 32'(rd), 32'(v[11:7]));
      chk("funct3", 32'(funct3), 32'(v[14:12]));
      chk("rs1", 32'(rs1), 32'(v[19:15]));
      chk("rs2", 32'(rs2), 32'(v[24:20]));
      chk("funct7", 32'(funct7), 32'(v[31:25]));
      chk("imm", imm, e.imm);
      chk("fmt", 32'(fmt), 32'(e.fmt));
      chk("alu_op", 32'(alu_op), 32'(e.alu));
      chk("alu_src_imm", 32'(alu_src_imm), 32'(e.src));
      chk("reg_write", 32'(reg_write), 32'(e.rw));
      chk("mem_read", 32'(mem_read), 32'(e.mr));
      chk("mem_write", 32'(mem_write), 32'(e.mw));
      chk("branch", 32'(branch), 32'(e.br));
      chk("jump", 32'(jump), 32'(e.jp));
      chk("illegal", 32'(illegal), 32'(e.ill));
   endtask

   task automatic check_reset();
      chk("rst_fields", {opcode, rd, funct3, rs1, rs2, funct7}, 32'h0);
      chk("rst_imm", imm, 32'h0);
      chk("rst_fmt", 32'(fmt), 32'd7);
      chk("rst_alu_op", 32'(alu_op), 32'h0);
      chk("rst_ctrl", 32'({alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal}), 32'h0);
   endtask

   // Drive on the falling edge, sample 1ns after the next rising edge
   task automatic step(input logic [31:0] v, input logic r);
      @(negedge clk);
      inst = v;
      rst  = r;
      @(posedge clk);
      #1;
      cur_inst = v;
      if (r) check_reset();
      else check_decode(v);
   endtask

   initial begin
      logic [31:0] v;
      rst  = 1'b1;
      inst = 32'h002081B3;
      cur_inst = inst;
      repeat (2) @(posedge clk);
      #1;
      check_reset();
      step(32'h002081B3, 1'b0);
      chk("add_alu", 32'(alu_op), 32'(A_ADD));
      chk("add_fmt", 32'(fmt), 32'd0);
      step(32'hFFF00093, 1'b0);
      chk("addi_imm", imm, 32'hFFFF_FFFF);
      step(32'h40208133, 1'b0);
      chk("sub_alu", 32'(alu_op), 32'(A_SUB));
      step(32'h0020A423, 1'b0);
      chk("sw_imm", imm, 32'd8);
      step(32'h00208463, 1'b0);
      chk("beq_imm", imm, 32'd8);
      step(32'h123452B7, 1'b0);
      chk("lui_imm", imm, 32'h1234_5000);
      chk("lui_alu", 32'(alu_op), 32'(A_PASS_B));
      step(32'h00000000, 1'b0);
      chk("zero_illegal", 32'(illegal), 32'd1);
      chk("zero_fmt", 32'(fmt), 32'd7);
      step(32'h002081B3, 1'b1);
      step(32'h0020A423, 1'b0);
      for (int n = 0; n < 800; n++) begin
         v = $urandom;
         if ($urandom_range(0, 11) != 11) v[6:0] = opcs[$urandom_range(0, 10)];
         case ($urandom_range(0, 2))
            0: v[31:25] = 7'h00;
            1: v[31:25] = 7'h20;
            default: ;
         endcase
         step(v, $urandom_range(0, 49) == 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
